// File: rtl/output_pkg.sv
// rtl/output_pkg.sv - shared widths and drain FSM state type for the output drain path
package output_pkg;

  localparam int DEF_I_WIDTH         = 8;
  localparam int DEF_F_WIDTH         = 8;
  localparam int DEF_W               = DEF_I_WIDTH + DEF_F_WIDTH;
  localparam int DEF_BRAM_ADDR_WIDTH = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// rtl/drain_fifo.sv - 2-entry synchronous FIFO between BRAM read data and the result stream
module drain_fifo
  import output_pkg::*;
#(
  parameter int WIDTH = DEF_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/output_drain.sv
// rtl/output_drain.sv - streams accumulated words out of the output BRAM, optional ReLU and zero-clear
module output_drain
  import output_pkg::*;
#(
  parameter int I_WIDTH         = DEF_I_WIDTH,
  parameter int F_WIDTH         = DEF_F_WIDTH,
  parameter int BRAM_ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [BRAM_ADDR_WIDTH:0]           count_i,
  input  logic                               clear_en_i,
  input  logic                               relu_en_i,
  output logic [BRAM_ADDR_WIDTH-1:0]         bram_rd_addr_o,
  output logic                               bram_rd_en_o,
  input  logic signed [I_WIDTH+F_WIDTH-1:0]  bram_rd_data_i,
  output logic                               bram_wr_en_o,
  output logic [BRAM_ADDR_WIDTH-1:0]         bram_wr_addr_o,
  output logic [I_WIDTH+F_WIDTH-1:0]         bram_wr_data_o,
  output logic signed [I_WIDTH+F_WIDTH-1:0]  m_data_o,
  output logic                               m_valid_o,
  input  logic                               m_ready_i,
  output logic                               m_last_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int          W       = I_WIDTH + F_WIDTH;
  localparam int          AW      = BRAM_ADDR_WIDTH;
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  drain_state_t  state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   issued_q, issued_d;
  logic          clear_q, clear_d;
  logic          relu_q, relu_d;
  logic          infl_q, infl_d;
  logic [AW-1:0] infl_addr_q, infl_addr_d;
  logic          infl_last_q, infl_last_d;

  logic [1:0]    fifo_cnt;
  logic [W:0]    fifo_dout;
  logic [W-1:0]  push_word;
  logic          fifo_valid;
  logic          pop;
  logic          rd_ok;
  logic          rd_en;
  logic          rd_is_last;
  logic [AW-1:0] rd_addr;

  assign fifo_valid = (fifo_cnt != 2'd0);
  assign pop        = fifo_valid & m_ready_i;
  assign rd_addr    = base_q + issued_q[AW-1:0];
  assign rd_is_last = (issued_q == count_q - CNT_ONE);
  // Occupancy plus the in-flight read, less this cycle's pop, must leave room for one more word.
  assign rd_ok      = ({1'b0, fifo_cnt} + {2'b00, infl_q}) <= (3'd1 + {2'b00, pop});
  assign push_word  = (relu_q && bram_rd_data_i[W-1]) ? '0 : bram_rd_data_i;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    issued_d    = issued_q;
    clear_d     = clear_q;
    relu_d      = relu_q;
    rd_en       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          count_d  = count_i;
          clear_d  = clear_en_i;
          relu_d   = relu_en_i;
          issued_d = '0;
          state_d  = (count_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (rd_ok) begin
          rd_en    = 1'b1;
          issued_d = issued_q + CNT_ONE;
          if (rd_is_last) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (pop && fifo_dout[W]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    infl_d      = rd_en;
    infl_addr_d = rd_en ? rd_addr : infl_addr_q;
    infl_last_d = rd_en ? rd_is_last : infl_last_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      clear_q     <= 1'b0;
      relu_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      issued_q    <= issued_d;
      clear_q     <= clear_d;
      relu_q      <= relu_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
    end
  end

  drain_fifo #(
    .WIDTH(W + 1)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (infl_q),
    .data_i  ({infl_last_q, push_word}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .count_o (fifo_cnt)
  );

  assign bram_rd_en_o   = rd_en;
  assign bram_rd_addr_o = rd_en ? rd_addr : '0;
  assign bram_wr_en_o   = infl_q & clear_q;
  assign bram_wr_addr_o = (infl_q & clear_q) ? infl_addr_q : '0;
  assign bram_wr_data_o = '0;
  assign m_valid_o      = fifo_valid;
  assign m_data_o       = fifo_dout[W-1:0];
  assign m_last_o       = fifo_valid & fifo_dout[W];

endmodule

// File: tb/tb_output_drain.sv
// tb/tb_output_drain.sv - directed self-checking bench for output_drain with a dual-port BRAM model
module tb_output_drain;

  localparam int AW = 11;
  localparam int W  = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [AW-1:0]       base;
  logic [AW:0]         count;
  logic                clear_en;
  logic                relu_en;
  logic [AW-1:0]       rd_addr;
  logic                rd_en;
  logic signed [W-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [W-1:0]        wr_data;
  logic signed [W-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  output_drain #(.I_WIDTH(8), .F_WIDTH(8), .BRAM_ADDR_WIDTH(AW)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .base_addr_i    (base),
    .count_i        (count),
    .clear_en_i     (clear_en),
    .relu_en_i      (relu_en),
    .bram_rd_addr_o (rd_addr),
    .bram_rd_en_o   (rd_en),
    .bram_rd_data_i (rd_data),
    .bram_wr_en_o   (wr_en),
    .bram_wr_addr_o (wr_addr),
    .bram_wr_data_o (wr_data),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .m_last_o       (m_last),
    .busy_o         (busy),
    .done_o         (done)
  );

  logic [W-1:0]  mem [2048];
  logic          lat_rd_en, lat_wr_en;
  logic [AW-1:0] lat_rd_addr, lat_wr_addr;
  logic [W-1:0]  lat_wr_data;
  int            cyc = 0;

  logic [AW-1:0] rd_log [$];
  logic [W:0]    beats [$];
  int            beat_cyc [$];
  int            rd_total, wr_total, acc_total, max_out, stab_viol, done_cyc;
  logic          prev_stall;
  logic [W-1:0]  prev_data;
  logic          prev_last;

  int n_cmp = 0;
  int n_bad = 0;

  // Outputs are sampled mid-cycle; the BRAM model acts on the following rising edge.
  always @(negedge clk) begin
    lat_rd_en   = rd_en;
    lat_rd_addr = rd_addr;
    lat_wr_en   = wr_en;
    lat_wr_addr = wr_addr;
    lat_wr_data = wr_data;
    if (rd_en) begin
      rd_log.push_back(rd_addr);
      rd_total++;
    end
    if (wr_en) wr_total++;
    if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_viol++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (m_valid && m_ready) begin
      beats.push_back({m_last, m_data});
      beat_cyc.push_back(cyc);
      acc_total++;
    end
    if (rd_total - acc_total > max_out) max_out = rd_total - acc_total;
    if (done) done_cyc = cyc;
  end

  always @(posedge clk) begin
    cyc++;
    if (lat_rd_en) rd_data <= mem[lat_rd_addr];
    if (lat_wr_en) mem[lat_wr_addr] = lat_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_log.delete();
    beats.delete();
    beat_cyc.delete();
    rd_total = 0; wr_total = 0; acc_total = 0; max_out = 0; stab_viol = 0;
    done_cyc = -1; prev_stall = 1'b0;
  endtask

  task automatic start_drain(input int b, input int n, input logic clr, input logic rl);
    base     = b[AW-1:0];
    count    = n[AW:0];
    clear_en = clr;
    relu_en  = rl;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit bp);
    int k = 0;
    while (!done && k < 200) begin
      if (bp) m_ready = (k % 3 == 0);
      @(posedge clk); #1;
      k++;
    end
    m_ready = 1'b1;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic check_stream(input string tag, input logic [W:0] exp [$]);
    logic [31:0] obs;
    check({tag, "_nbeats"}, beats.size(), exp.size());
    foreach (exp[i]) begin
      obs = (i < beats.size()) ? 32'(beats[i]) : 32'hxxxx_xxxx;
      check($sformatf("%s_beat%0d", tag, i), obs, 32'(exp[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, {26'd0, m_valid, m_last, rd_en, wr_en, busy, done}, 32'd0);
    check({tag, "_addr"}, {10'd0, rd_addr, wr_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, m_data}, 32'd0);
  endtask

  logic [W:0] e [$];

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; count = '0;
    clear_en = 1'b0; relu_en = 1'b0; m_ready = 1'b1; rd_data = '0;
    lat_rd_en = 1'b0; lat_wr_en = 1'b0; lat_rd_addr = '0; lat_wr_addr = '0; lat_wr_data = '0;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[10] = 16'h0005; mem[11] = 16'hFFFD; mem[12] = 16'h7FFF; mem[13] = 16'h8000;
    mem[2046] = 16'h0011; mem[2047] = 16'h0022; mem[0] = 16'h0033; mem[1] = 16'h0044;
    for (int i = 0; i < 8; i++) mem[100 + i] = 16'(16'h0100 + i);
    clear_log();

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic drain with first-word latency
    clear_log();
    start_drain(10, 4, 1'b0, 1'b0);
    check("basic_e0_rd", {20'd0, busy, rd_en, rd_addr}, {20'd0, 1'b1, 1'b1, 11'd10});
    @(posedge clk); #1;
    check("basic_e1", {20'd0, m_valid, rd_en, rd_addr}, {20'd0, 1'b0, 1'b1, 11'd11});
    @(posedge clk); #1;
    check("basic_e2", {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0005});
    wait_done("basic", 1'b0);
    e = '{17'h00005, 17'h0FFFD, 17'h07FFF, 17'h18000};
    check_stream("basic", e);
    check("basic_consec", beat_cyc[3] - beat_cyc[0], 32'd3);
    check("basic_done_cyc", done_cyc - beat_cyc[3], 32'd1);
    check("basic_no_wr", wr_total, 32'd0);
    check("basic_mem", {mem[10], mem[13]}, {16'h0005, 16'h8000});

    // Clear + ReLU
    clear_log();
    start_drain(10, 4, 1'b1, 1'b1);
    wait_done("clrrelu", 1'b0);
    e = '{17'h00005, 17'h00000, 17'h07FFF, 17'h10000};
    check_stream("clrrelu", e);
    check("clrrelu_wr", wr_total, 32'd4);
    check("clrrelu_mem", {mem[10], mem[11]}, 32'd0);
    check("clrrelu_mem2", {mem[12], mem[13]}, 32'd0);
    clear_log();
    start_drain(10, 4, 1'b0, 1'b0);
    wait_done("reread", 1'b0);
    e = '{17'h00000, 17'h00000, 17'h00000, 17'h10000};
    check_stream("reread", e);

    // Wrap-around
    clear_log();
    start_drain(2046, 4, 1'b0, 1'b0);
    wait_done("wrap", 1'b0);
    check("wrap_addr0", 32'(rd_log[0]), 32'd2046);
    check("wrap_addr1", 32'(rd_log[1]), 32'd2047);
    check("wrap_addr2", 32'(rd_log[2]), 32'd0);
    check("wrap_addr3", 32'(rd_log[3]), 32'd1);
    e = '{17'h00011, 17'h00022, 17'h00033, 17'h10044};
    check_stream("wrap", e);

    // Backpressure
    clear_log();
    start_drain(100, 8, 1'b0, 1'b0);
    wait_done("bp", 1'b1);
    e = '{17'h00100, 17'h00101, 17'h00102, 17'h00103,
          17'h00104, 17'h00105, 17'h00106, 17'h10107};
    check_stream("bp", e);
    check("bp_stable", stab_viol, 32'd0);
    check("bp_outstanding_le2", {31'd0, (max_out <= 2)}, 32'd1);
    check("bp_reads", rd_total, 32'd8);

    // Zero count
    clear_log();
    start_drain(10, 0, 1'b1, 1'b0);
    check("zero_e0", {29'd0, done, busy, rd_en}, {29'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("zero_e1", {30'd0, done, m_valid}, 32'd0);
    check("zero_io", {rd_total[15:0], wr_total[15:0]}, 32'd0);

    // Start pulsed while running is ignored
    clear_log();
    start_drain(2046, 4, 1'b0, 1'b0);
    base = 11'd500; count = 12'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busystart", 1'b0);
    e = '{17'h00011, 17'h00022, 17'h00033, 17'h10044};
    check_stream("busystart", e);
    check("busystart_reads", rd_total, 32'd4);

    // Reset mid-drain
    clear_log();
    start_drain(2046, 4, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_after", {30'd0, m_valid, busy}, 32'd0);
    clear_log();
    start_drain(100, 3, 1'b0, 1'b0);
    wait_done("postrst", 1'b0);
    e = '{17'h00100, 17'h00101, 17'h10102};
    check_stream("postrst", e);
    check("postrst_addr0", 32'(rd_log[0]), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
